// File: rtl/dispatch_stage_if.sv
// Interface bundling every non-clock signal of the dispatch stage.
//   in_*        : rename -> dispatch handshake and instruction fields
//   out_*       : dispatch -> integer issue queue handshake, fields, source state
//   writeback*  : two writeback ports that clear busy bits (and bypass state)
//   flush_*     : redirect flush with the ROB index of the redirecting instruction
// Modports:
//   slave  : the dispatch stage itself
//   master : the surrounding pipeline (rename, issue queue, writeback, redirect)
interface dispatch_stage_if #(
  parameter int PREG_W    = 6,
  parameter int ROB_LOG   = 6,
  parameter int PAYLOAD_W = 256
);
  // rename side
  logic                 in_valid;
  logic                 in_ready;
  logic [PREG_W-1:0]    in_prs1;
  logic [PREG_W-1:0]    in_prs2;
  logic [PREG_W-1:0]    in_prd;
  logic                 in_src1_is_reg;
  logic                 in_src2_is_reg;
  logic                 in_need_to_wb;
  logic                 in_robidx_flag;
  logic [ROB_LOG-1:0]   in_robidx;
  logic [PAYLOAD_W-1:0] in_payload;

  // issue-queue side
  logic                 out_valid;
  logic                 out_ready;
  logic [PREG_W-1:0]    out_prs1;
  logic [PREG_W-1:0]    out_prs2;
  logic [PREG_W-1:0]    out_prd;
  logic                 out_src1_is_reg;
  logic                 out_src2_is_reg;
  logic                 out_need_to_wb;
  logic                 out_robidx_flag;
  logic [ROB_LOG-1:0]   out_robidx;
  logic [PAYLOAD_W-1:0] out_payload;
  logic                 out_src1_state;
  logic                 out_src2_state;

  // writeback ports
  logic                 writeback0_valid;
  logic                 writeback0_need_to_wb;
  logic [PREG_W-1:0]    writeback0_prd;
  logic                 writeback1_valid;
  logic                 writeback1_need_to_wb;
  logic [PREG_W-1:0]    writeback1_prd;

  // redirect
  logic                 flush_valid;
  logic                 flush_robidx_flag;
  logic [ROB_LOG-1:0]   flush_robidx;

  modport slave (
    input  in_valid, in_prs1, in_prs2, in_prd, in_src1_is_reg, in_src2_is_reg,
           in_need_to_wb, in_robidx_flag, in_robidx, in_payload,
    output in_ready,
    output out_valid, out_prs1, out_prs2, out_prd, out_src1_is_reg, out_src2_is_reg,
           out_need_to_wb, out_robidx_flag, out_robidx, out_payload,
           out_src1_state, out_src2_state,
    input  out_ready,
    input  writeback0_valid, writeback0_need_to_wb, writeback0_prd,
           writeback1_valid, writeback1_need_to_wb, writeback1_prd,
    input  flush_valid, flush_robidx_flag, flush_robidx
  );

  modport master (
    output in_valid, in_prs1, in_prs2, in_prd, in_src1_is_reg, in_src2_is_reg,
           in_need_to_wb, in_robidx_flag, in_robidx, in_payload,
    input  in_ready,
    input  out_valid, out_prs1, out_prs2, out_prd, out_src1_is_reg, out_src2_is_reg,
           out_need_to_wb, out_robidx_flag, out_robidx, out_payload,
           out_src1_state, out_src2_state,
    output out_ready,
    output writeback0_valid, writeback0_need_to_wb, writeback0_prd,
           writeback1_valid, writeback1_need_to_wb, writeback1_prd,
    output flush_valid, flush_robidx_flag, flush_robidx
  );
endinterface

// File: rtl/dispatch_stage.sv
// Single-issue dispatch stage between rename and the integer issue queue.
// Holds one renamed instruction in a pipeline register and owns the
// physical-register busy table.
// Ports:
//   clock   : clock
//   reset_n : asynchronous active-low reset (clears held valid and busy table)
//   ifc     : dispatch_stage_if.slave -- rename handshake (in_*), issue-queue
//             handshake (out_*), per-source busy state with same-cycle
//             writeback bypass (out_src*_state), writeback ports 0/1 and flush.
module dispatch_stage #(
  parameter int PREG_NUM  = 64,
  parameter int PREG_W    = 6,
  parameter int ROB_LOG   = 6,
  parameter int PAYLOAD_W = 256
) (
  input  logic            clock,
  input  logic            reset_n,
  dispatch_stage_if.slave ifc
);

  logic                 in_ready_c;
  logic                 accept;
  logic                 younger;
  logic                 kill;
  logic                 wb0_clr;
  logic                 wb1_clr;

  logic                 vld_p1;
  logic [PREG_W-1:0]    prs1_p1;
  logic [PREG_W-1:0]    prs2_p1;
  logic [PREG_W-1:0]    prd_p1;
  logic                 src1_is_reg_p1;
  logic                 src2_is_reg_p1;
  logic                 need_to_wb_p1;
  logic                 robidx_flag_p1;
  logic [ROB_LOG-1:0]   robidx_p1;
  logic [PAYLOAD_W-1:0] payload_p1;

  logic [PREG_NUM-1:0]  busy;
  logic [PREG_NUM-1:0]  busy_nxt;

  // A source is still waiting when it reads a non-zero preg that is busy and
  // is not being written back in this very cycle. The issue queue only starts
  // snooping writebacks one cycle later, so the bypass here is what keeps a
  // same-cycle wakeup from being lost.
  function automatic logic src_busy(
    input logic                is_reg,
    input logic [PREG_W-1:0]   prs,
    input logic [PREG_NUM-1:0] tbl,
    input logic                clr0,
    input logic [PREG_W-1:0]   prd0,
    input logic                clr1,
    input logic [PREG_W-1:0]   prd1
  );
    logic hit0;
    logic hit1;
    hit0 = clr0 & (prd0 == prs);
    hit1 = clr1 & (prd1 == prs);
    return is_reg & (prs != '0) & tbl[prs] & ~hit0 & ~hit1;
  endfunction

  assign wb0_clr = ifc.writeback0_valid & ifc.writeback0_need_to_wb;
  assign wb1_clr = ifc.writeback1_valid & ifc.writeback1_need_to_wb;

  // A flush cycle never accepts: the incoming instruction may itself be on
  // the wrong path and rename will replay after the redirect.
  assign in_ready_c = ~ifc.flush_valid & (~vld_p1 | ifc.out_ready);
  assign accept     = ifc.in_valid & in_ready_c;

  // Age compare across the ROB wrap: with equal flags the smaller index is
  // older; differing flags invert that sense.
  assign younger = (ifc.flush_robidx_flag ^ robidx_flag_p1) ^ (ifc.flush_robidx < robidx_p1);
  assign kill    = ifc.flush_valid & vld_p1 & younger;

  // ---- stage p1: held instruction register ----
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1 <= 1'b0;
    end else if (accept) begin
      vld_p1 <= 1'b1;
    end else if (kill | ifc.out_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  // Data is only loaded on accept; it is meaningless while vld_p1 is low.
  always_ff @(posedge clock) begin
    if (accept) begin
      prs1_p1        <= ifc.in_prs1;
      prs2_p1        <= ifc.in_prs2;
      prd_p1         <= ifc.in_prd;
      src1_is_reg_p1 <= ifc.in_src1_is_reg;
      src2_is_reg_p1 <= ifc.in_src2_is_reg;
      need_to_wb_p1  <= ifc.in_need_to_wb;
      robidx_flag_p1 <= ifc.in_robidx_flag;
      robidx_p1      <= ifc.in_robidx;
      payload_p1     <= ifc.in_payload;
    end
  end

  // ---- busy table ----
  // Clears are applied before the set so that a preg reallocated in the same
  // cycle as its old writeback ends up busy. Preg 0 is the zero register.
  always_comb begin
    busy_nxt = busy;
    if (wb0_clr) busy_nxt[ifc.writeback0_prd] = 1'b0;
    if (wb1_clr) busy_nxt[ifc.writeback1_prd] = 1'b0;
    if (accept & ifc.in_need_to_wb & (ifc.in_prd != '0)) busy_nxt[ifc.in_prd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  // ---- outputs ----
  assign ifc.in_ready        = in_ready_c;
  assign ifc.out_valid       = vld_p1;
  assign ifc.out_prs1        = prs1_p1;
  assign ifc.out_prs2        = prs2_p1;
  assign ifc.out_prd         = prd_p1;
  assign ifc.out_src1_is_reg = src1_is_reg_p1;
  assign ifc.out_src2_is_reg = src2_is_reg_p1;
  assign ifc.out_need_to_wb  = need_to_wb_p1;
  assign ifc.out_robidx_flag = robidx_flag_p1;
  assign ifc.out_robidx      = robidx_p1;
  assign ifc.out_payload     = payload_p1;

  // Gated by vld_p1 so the state reads 0 after reset even though the
  // unreset data registers hold arbitrary preg numbers.
  assign ifc.out_src1_state = vld_p1 & src_busy(src1_is_reg_p1, prs1_p1, busy,
                                                wb0_clr, ifc.writeback0_prd,
                                                wb1_clr, ifc.writeback1_prd);
  assign ifc.out_src2_state = vld_p1 & src_busy(src2_is_reg_p1, prs2_p1, busy,
                                                wb0_clr, ifc.writeback0_prd,
                                                wb1_clr, ifc.writeback1_prd);

endmodule

// File: tb/tb_dispatch_stage.sv
module tb_dispatch_stage;
  localparam int PREG_NUM  = 64;
  localparam int PREG_W    = 6;
  localparam int ROB_LOG   = 6;
  localparam int PAYLOAD_W = 256;

  typedef struct {
    bit                 in_valid;
    bit [PREG_W-1:0]    prs1, prs2, prd;
    bit                 s1r, s2r, nwb, flag;
    bit [ROB_LOG-1:0]   idx;
    bit [PAYLOAD_W-1:0] payload;
    bit                 out_ready;
    bit                 wb0v, wb0n;
    bit [PREG_W-1:0]    wb0p;
    bit                 wb1v, wb1n;
    bit [PREG_W-1:0]    wb1p;
    bit                 fv, ff;
    bit [ROB_LOG-1:0]   fidx;
  } stim_t;

  typedef struct {
    bit [PREG_W-1:0]    prs1, prs2, prd;
    bit                 s1r, s2r, nwb, flag;
    bit [ROB_LOG-1:0]   idx;
    bit [PAYLOAD_W-1:0] payload;
  } inst_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  dispatch_stage_if #(.PREG_W(PREG_W), .ROB_LOG(ROB_LOG), .PAYLOAD_W(PAYLOAD_W)) ifc ();

  dispatch_stage #(
    .PREG_NUM(PREG_NUM), .PREG_W(PREG_W), .ROB_LOG(ROB_LOG), .PAYLOAD_W(PAYLOAD_W)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .ifc     (ifc)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: queue of instructions the stage owes the issue queue
  // (front = held entry) and one busy bit per preg.
  inst_t exp_q[$];
  bit    mbusy [PREG_NUM];
  bit    acc_now = 1'b0;
  inst_t acc_inst;

  task automatic chk(input string name, input logic [PAYLOAD_W-1:0] act, input logic [PAYLOAD_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic bit [PAYLOAD_W-1:0] rpay();
    bit [PAYLOAD_W-1:0] p;
    for (int i = 0; i < PAYLOAD_W / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '{default: 0};
    s.out_ready = 1'b1;
    return s;
  endfunction

  function automatic stim_t ins(input int p1, input int p2, input int pd,
                                input bit fl, input int ix, input bit rdy);
    stim_t s;
    s = idle_s();
    s.in_valid = 1'b1;
    s.prs1 = PREG_W'(p1);
    s.prs2 = PREG_W'(p2);
    s.prd  = PREG_W'(pd);
    s.s1r = 1'b1;
    s.s2r = 1'b1;
    s.nwb = 1'b1;
    s.flag = fl;
    s.idx = ROB_LOG'(ix);
    s.payload = rpay();
    s.out_ready = rdy;
    return s;
  endfunction

  function automatic stim_t rand_s();
    stim_t s;
    s.in_valid = ($urandom % 4) != 0;
    s.prs1 = PREG_W'($urandom % 16);
    s.prs2 = PREG_W'($urandom % 16);
    s.prd  = PREG_W'($urandom % 16);
    s.s1r = $urandom % 2;
    s.s2r = $urandom % 2;
    s.nwb = ($urandom % 4) != 0;
    s.flag = $urandom % 2;
    s.idx = ROB_LOG'($urandom);
    s.payload = rpay();
    s.out_ready = ($urandom % 4) != 0;
    s.wb0v = ($urandom % 3) == 0;
    s.wb0n = ($urandom % 4) != 0;
    s.wb0p = PREG_W'($urandom % 16);
    s.wb1v = ($urandom % 3) == 0;
    s.wb1n = ($urandom % 4) != 0;
    s.wb1p = PREG_W'($urandom % 16);
    s.fv = ($urandom % 8) == 0;
    s.ff = $urandom % 2;
    s.fidx = ROB_LOG'($urandom);
    return s;
  endfunction

  function automatic inst_t to_inst(input stim_t s);
    inst_t t;
    t.prs1 = s.prs1; t.prs2 = s.prs2; t.prd = s.prd;
    t.s1r = s.s1r; t.s2r = s.s2r; t.nwb = s.nwb; t.flag = s.flag;
    t.idx = s.idx; t.payload = s.payload;
    return t;
  endfunction

  task automatic apply(input stim_t s);
    ifc.in_valid = s.in_valid;
    ifc.in_prs1 = s.prs1;
    ifc.in_prs2 = s.prs2;
    ifc.in_prd = s.prd;
    ifc.in_src1_is_reg = s.s1r;
    ifc.in_src2_is_reg = s.s2r;
    ifc.in_need_to_wb = s.nwb;
    ifc.in_robidx_flag = s.flag;
    ifc.in_robidx = s.idx;
    ifc.in_payload = s.payload;
    ifc.out_ready = s.out_ready;
    ifc.writeback0_valid = s.wb0v;
    ifc.writeback0_need_to_wb = s.wb0n;
    ifc.writeback0_prd = s.wb0p;
    ifc.writeback1_valid = s.wb1v;
    ifc.writeback1_need_to_wb = s.wb1n;
    ifc.writeback1_prd = s.wb1p;
    ifc.flush_valid = s.fv;
    ifc.flush_robidx_flag = s.ff;
    ifc.flush_robidx = s.fidx;
  endtask

  // Issue one cycle of stimulus; if the model says it is accepted, the
  // instruction becomes an expected output.
  task automatic drive_cycle(input stim_t s);
    @(posedge clock);
    #1;
    apply(s);
    acc_now = s.in_valid && !s.fv && (exp_q.size() == 0 || s.out_ready);
    if (acc_now) begin
      acc_inst = to_inst(s);
      exp_q.push_back(acc_inst);
    end
  endtask

  task automatic reset_mid();
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    apply(idle_s());
    exp_q.delete();
    for (int i = 0; i < PREG_NUM; i++) mbusy[i] = 1'b0;
    acc_now = 1'b0;
    #1;
    chk("async_rst_out_valid", ifc.out_valid, 1'b0);
    chk("async_rst_src1_state", ifc.out_src1_state, 1'b0);
    chk("async_rst_src2_state", ifc.out_src2_state, 1'b0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  // Monitor: compares DUT outputs against the model every cycle, then
  // advances the model across the coming clock edge.
  int    held_n;
  inst_t h;
  bit    yng, hit0, hit1, e1, e2;

  always @(negedge clock) begin
    if (reset_n) begin
      held_n = exp_q.size() - int'(acc_now);
      chk("in_ready", ifc.in_ready, !ifc.flush_valid && (held_n == 0 || ifc.out_ready));
      chk("out_valid", ifc.out_valid, held_n > 0);
      if (held_n > 0) begin
        h = exp_q[0];
        chk("out_prs1", ifc.out_prs1, h.prs1);
        chk("out_prs2", ifc.out_prs2, h.prs2);
        chk("out_prd", ifc.out_prd, h.prd);
        chk("out_flags", {ifc.out_src1_is_reg, ifc.out_src2_is_reg, ifc.out_need_to_wb, ifc.out_robidx_flag},
            {h.s1r, h.s2r, h.nwb, h.flag});
        chk("out_robidx", ifc.out_robidx, h.idx);
        chk("out_payload", ifc.out_payload, h.payload);
        hit0 = ifc.writeback0_valid && ifc.writeback0_need_to_wb && ifc.writeback0_prd == h.prs1;
        hit1 = ifc.writeback1_valid && ifc.writeback1_need_to_wb && ifc.writeback1_prd == h.prs1;
        e1 = h.s1r && h.prs1 != 0 && mbusy[h.prs1] && !hit0 && !hit1;
        hit0 = ifc.writeback0_valid && ifc.writeback0_need_to_wb && ifc.writeback0_prd == h.prs2;
        hit1 = ifc.writeback1_valid && ifc.writeback1_need_to_wb && ifc.writeback1_prd == h.prs2;
        e2 = h.s2r && h.prs2 != 0 && mbusy[h.prs2] && !hit0 && !hit1;
        chk("src1_state", ifc.out_src1_state, e1);
        chk("src2_state", ifc.out_src2_state, e2);
        // Entry leaves on a younger flush or on issue-queue acceptance.
        if (h.flag == ifc.flush_robidx_flag) yng = ifc.flush_robidx < h.idx;
        else                                 yng = !(ifc.flush_robidx < h.idx);
        if ((ifc.flush_valid && yng) || ifc.out_ready) void'(exp_q.pop_front());
      end
      if (ifc.writeback0_valid && ifc.writeback0_need_to_wb) mbusy[ifc.writeback0_prd] = 1'b0;
      if (ifc.writeback1_valid && ifc.writeback1_need_to_wb) mbusy[ifc.writeback1_prd] = 1'b0;
      if (acc_now && acc_inst.nwb && acc_inst.prd != 0) mbusy[acc_inst.prd] = 1'b1;
    end
  end

  initial begin
    stim_t s;
    for (int i = 0; i < PREG_NUM; i++) mbusy[i] = 1'b0;
    apply(idle_s());
    #1;
    chk("rst_out_valid", ifc.out_valid, 1'b0);
    chk("rst_src1_state", ifc.out_src1_state, 1'b0);
    chk("rst_src2_state", ifc.out_src2_state, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // single instruction, then a consumer of its prd
    drive_cycle(ins(5, 0, 9, 0, 1, 1));
    drive_cycle(ins(9, 9, 0, 0, 2, 1));
    drive_cycle(idle_s());
    drive_cycle(idle_s());

    // producer 12 then consumer 12; wakeup via same-cycle bypass
    drive_cycle(ins(0, 0, 12, 0, 3, 1));
    drive_cycle(ins(12, 0, 13, 0, 4, 1));
    s = idle_s(); s.out_ready = 1'b0;
    drive_cycle(s);
    s = idle_s(); s.wb0v = 1'b1; s.wb0n = 1'b1; s.wb0p = 12;
    drive_cycle(s);

    // stall with a writeback on the held prs2, then release
    drive_cycle(ins(0, 0, 7, 0, 5, 1));
    drive_cycle(ins(3, 7, 14, 0, 6, 1));
    drive_cycle(ins(1, 2, 15, 0, 7, 0));
    s = ins(1, 2, 15, 0, 7, 0); s.wb1v = 1'b1; s.wb1n = 1'b1; s.wb1p = 7;
    drive_cycle(s);
    drive_cycle(ins(1, 2, 15, 0, 7, 0));
    drive_cycle(ins(1, 2, 15, 0, 7, 1));
    drive_cycle(idle_s());

    // younger entry killed even with out_ready=1, older one survives
    drive_cycle(ins(0, 0, 0, 0, 10, 1));
    s = ins(4, 4, 16, 0, 11, 1); s.fv = 1'b1; s.ff = 1'b0; s.fidx = 7;
    drive_cycle(s);
    drive_cycle(idle_s());
    drive_cycle(ins(0, 0, 0, 0, 10, 1));
    s = ins(4, 4, 16, 0, 11, 0); s.fv = 1'b1; s.ff = 1'b0; s.fidx = 12;
    drive_cycle(s);
    drive_cycle(idle_s());
    drive_cycle(idle_s());

    // set beats clear on the same preg; prd=0 / need_to_wb=0 leave table alone
    s = ins(0, 0, 20, 0, 12, 1); s.wb0v = 1'b1; s.wb0n = 1'b1; s.wb0p = 20;
    drive_cycle(s);
    drive_cycle(ins(20, 0, 0, 0, 13, 1));
    s = ins(0, 0, 21, 0, 14, 1); s.nwb = 1'b0;
    drive_cycle(s);
    drive_cycle(ins(21, 0, 22, 0, 15, 1));
    drive_cycle(idle_s());

    // asynchronous reset while a stalled entry is held
    drive_cycle(ins(9, 20, 23, 0, 16, 1));
    drive_cycle(ins(1, 1, 24, 0, 17, 0));
    reset_mid();
    drive_cycle(ins(9, 20, 25, 0, 18, 1));
    drive_cycle(idle_s());

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if (($urandom % 600) == 0) reset_mid();
      drive_cycle(rand_s());
    end
    drive_cycle(idle_s());
    drive_cycle(idle_s());

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dispatch_stage.md
Name: dispatch_stage

Overview:
Single-issue dispatch stage between rename and the integer issue queue. Holds one renamed instruction in a pipeline register and owns the physical-register busy table. It supplies per-source busy state to the issue queue with a same-cycle writeback bypass, marks destination pregs busy on dispatch, and kills the held instruction on a younger-than-flush redirect.

Parameters:
PREG_NUM, 64, number of physical registers; preg 0 is hardwired zero and never busy
PREG_W, 6, physical register index width, log2(PREG_NUM)
ROB_LOG, 6, ROB index width, excluding the wrap flag
PAYLOAD_W, 256, width of the opaque payload passed through unchanged (pc, imm, types, ls_size, old_prd, ...)

Ports:
clock  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  rename has an instruction
in_ready  out  1  stage can accept this cycle
in_prs1  in  PREG_W  source 1 preg
in_prs2  in  PREG_W  source 2 preg
in_prd  in  PREG_W  destination preg
in_src1_is_reg  in  1  source 1 reads a register
in_src2_is_reg  in  1  source 2 reads a register
in_need_to_wb  in  1  instruction writes prd
in_robidx_flag  in  1  ROB wrap flag
in_robidx  in  ROB_LOG  ROB index
in_payload  in  PAYLOAD_W  opaque fields
out_valid  out  1  held instruction valid (drives issue-queue enq valid)
out_ready  in  1  issue-queue enq ready
out_prs1, out_prs2, out_prd  out  PREG_W each  registered copies
out_src1_is_reg, out_src2_is_reg, out_need_to_wb, out_robidx_flag  out  1 each  registered copies
out_robidx  out  ROB_LOG  registered copy
out_payload  out  PAYLOAD_W  registered copy
out_src1_state  out  1  1 = source 1 still busy (not ready)
out_src2_state  out  1  1 = source 2 still busy
writeback0_valid, writeback0_need_to_wb  in  1 each  writeback port 0
writeback0_prd  in  PREG_W  writeback port 0 preg
writeback1_valid, writeback1_need_to_wb  in  1 each  writeback port 1
writeback1_prd  in  PREG_W  writeback port 1 preg
flush_valid  in  1  redirect flush
flush_robidx_flag  in  1  flush ROB flag
flush_robidx  in  ROB_LOG  flush ROB index

Behaviour:
- Reset (asynchronous): out_valid=0; busy table all 0. Data registers are not reset; out_* data is don't-care while out_valid=0, but out_src*_state must read 0 after reset.
- in_ready = ~flush_valid & (~out_valid | out_ready). Accept = in_valid & in_ready; all in_* fields are captured on the next clock edge and out_valid becomes 1. Latency is one cycle.
- Hold: while out_valid & ~out_ready, all out_* registers are stable.
- Dequeue: on out_valid & out_ready with no accept, out_valid becomes 0. Back-to-back accept and dequeue in the same cycle sustains one instruction per cycle.
- Flush: the held entry is younger when (flush_robidx_flag ^ out_robidx_flag) ^ (flush_robidx < out_robidx).
  - If flush_valid and the held entry is younger, out_valid becomes 0 next cycle, even if out_ready=1 in that cycle; the issue queue discards its own copy.
  - An older held entry survives.
  - No accept occurs during a flush cycle.
- Busy set: on accept with in_need_to_wb=1 and in_prd!=0, busy[in_prd] is set at the edge.
- Busy clear: writebackN_valid & writebackN_need_to_wb clears busy[writebackN_prd] at the edge; both ports may clear in the same cycle. If a set and a clear hit the same preg in one cycle, the set wins. Busy bits of flushed instructions are left as-is; reallocation re-sets them.
- Source state (combinational): out_srcK_state = out_srcK_is_reg & (out_prsK!=0) & busy[out_prsK] & ~(wb0 hit on out_prsK) & ~(wb1 hit on out_prsK).
  - The same-cycle bypass is mandatory: the issue queue only watches writebacks from the next cycle onward, so a missed bypass deadlocks it.
  - A held entry's state updates every cycle while stalled.
- Dependency visibility: a producer accepted in cycle N has its busy bit visible to a consumer accepted in cycle N+1. Its own prd never affects its own sources.

Test Plan:
- Reset then a single instruction (prs1=5, prs2=0, prd=9, both is_reg) with out_ready=1 -> out_valid=1 the next cycle, src1_state=0, src2_state=0, busy[9]=1.
- Producer prd=12, then consumer prs1=12 back-to-back with out_ready=1 -> consumer presented with src1_state=1; writeback0 of prd=12 asserted in the consumer's output cycle -> src1_state=0 in that same cycle.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs stable; writeback1 of the held entry's prs2 during the stall -> src2_state drops within the cycle; release -> the next instruction is accepted the same cycle.
- Held robidx flag=0, idx=10; flush flag=0, idx=7 -> out_valid=0 next cycle, in_ready=0 in the flush cycle. Repeat with flush idx=12 -> entry survives.
- Accept of prd=20 in the same cycle as writeback0 prd=20 -> busy[20]=1 afterwards. Accept with prd=0 or need_to_wb=0 -> no busy bit changes.
- Assert reset_n low mid-stall with out_valid=1 -> out_valid=0 immediately (asynchronously); the busy table clears, and a subsequent consumer of any preg sees state=0.
